// File: rtl/usb_pkg.sv
// Shared types for the USB endpoint transmit path: packet codes, commands,
// completion codes and the sequencer state encoding.
package usb_pkg;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA  = 3'd1,
        TX_ACK   = 3'd2,
        TX_NAK   = 3'd3,
        TX_STALL = 3'd4
    } tx_packet_t;

    localparam logic [7:0] CMD_DATA  = 8'd1;
    localparam logic [7:0] CMD_ACK   = 8'd2;
    localparam logic [7:0] CMD_NAK   = 8'd3;
    localparam logic [7:0] CMD_STALL = 8'd4;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TX      = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_BAD_CMD = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACTIVE,
        DONE,
        FLUSH
    } seq_state_t;

    // Unknown command values map to TX_NONE, which the sequencer treats as invalid.
    function automatic tx_packet_t cmd_to_packet(input logic [7:0] cmd);
        case (cmd)
            CMD_DATA:  return TX_DATA;
            CMD_ACK:   return TX_ACK;
            CMD_NAK:   return TX_NAK;
            CMD_STALL: return TX_STALL;
            default:   return TX_NONE;
        endcase
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Saturating cycle counter for the ISSUE wait; expired marks the last cycle
// the sequencer may keep waiting for the transmitter to start.
module seq_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && count_q != W'(LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Raised while counting the final allowed cycle, so the waiting state
    // lasts exactly LIMIT cycles.
    assign expired = enable && (count_q >= W'(LIMIT - 1));

endmodule

// File: rtl/tx_packet_sequencer.sv
// Endpoint transmit sequencer: accepts one tx_control command, drives the
// transmitter, reports completion and serialises data-buffer flushes.
module tx_packet_sequencer
    import usb_pkg::*;
#(
    parameter int START_TIMEOUT = 255,
    parameter int OCC_W         = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd,
    output logic             cmd_ready,
    input  logic             flush_req,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic             tx_transfer_active,
    input  logic             tx_error,
    output tx_packet_t       tx_packet,
    output logic             clear,
    output logic             clear_tx_control,
    output logic             clear_flush_ctrl,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code
);

    seq_state_t state_q, state_d;
    tx_packet_t code_q, code_d;
    err_code_t  err_q, err_d;
    logic       err_latch_q, err_latch_d;
    logic       flush_pend_q, flush_pend_d;
    logic       clear_q;
    logic       expired;

    seq_timeout_counter #(
        .LIMIT (START_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ISSUE),
        .enable  (state_q == ISSUE),
        .expired (expired)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        err_d        = err_q;
        err_latch_d  = err_latch_q;
        flush_pend_d = flush_pend_q;

        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (cmd_valid && !flush_pend_q) begin
                    if (cmd_to_packet(cmd) == TX_NONE ||
                        (cmd == CMD_DATA && buffer_occupancy == '0)) begin
                        state_d = DONE;
                        err_d   = ERR_BAD_CMD;
                    end else begin
                        state_d     = ISSUE;
                        code_d      = cmd_to_packet(cmd);
                        err_latch_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (flush_req) flush_pend_d = 1'b1;
                if (tx_transfer_active) begin
                    state_d = ACTIVE;
                end else if (expired) begin
                    state_d = DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ACTIVE: begin
                if (flush_req) flush_pend_d = 1'b1;
                if (tx_error) err_latch_d = 1'b1;
                if (!tx_transfer_active) begin
                    state_d = DONE;
                    err_d   = (err_latch_q || tx_error) ? ERR_TX : ERR_OK;
                end
            end
            DONE: begin
                err_latch_d = 1'b0;
                if (flush_req) flush_pend_d = 1'b1;
                state_d = (flush_pend_q || flush_req) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (buffer_occupancy == '0) begin
                    state_d      = IDLE;
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            code_q       <= TX_NONE;
            err_q        <= ERR_OK;
            err_latch_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            err_q        <= err_d;
            err_latch_q  <= err_latch_d;
            flush_pend_q <= flush_pend_d;
            clear_q      <= (state_d == FLUSH) && (state_q != FLUSH);
        end
    end

    assign cmd_ready        = (state_q == IDLE) && !flush_pend_q && !flush_req;
    assign tx_packet        = (state_q == ISSUE) ? code_q : TX_NONE;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign clear_tx_control = (state_q == DONE);
    assign err_code         = (state_q == DONE) ? err_q : ERR_OK;
    assign clear            = clear_q;
    assign clear_flush_ctrl = clear_q;

endmodule
